// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with round-robin replacement.
// Optional flush support is compiled in with `define CACHE_FLUSH_EN.
module set_assoc_cache #(
    parameter int CACHESIZEBITS = 13,
    parameter int BLOCKSIZEBITS = 2,
    parameter int WAYBITS       = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ProzessorSchreiben,
    input  logic        ProzessorLesen,
    input  logic [31:0] ProzessorAdresse,
    input  logic [31:0] ProzessorSchreibDaten,
    output logic [31:0] ProzessorLesDaten,
    output logic        ProzessorDatenGeschrieben,
    output logic        ProzessorDatenGelesen,
    output logic        RAMSchreiben,
    output logic        RAMLesen,
    output logic [31:0] RAMAdresse,
    output logic [31:0] RAMSchreibDaten,
    input  logic [31:0] RAMLesDaten,
    input  logic        RAMDatenGeschrieben,
    input  logic        RAMDatenGelesen
`ifdef CACHE_FLUSH_EN
    ,
    input  logic        Flush,
    output logic        FlushFertig
`endif
);

    localparam int SETBITS = CACHESIZEBITS - BLOCKSIZEBITS - WAYBITS;
    localparam int TAGBITS = 32 - SETBITS - BLOCKSIZEBITS;
    localparam int WAYS    = 1 << WAYBITS;
    localparam int SETS    = 1 << SETBITS;
    localparam int WORDS   = 1 << BLOCKSIZEBITS;
    localparam int WIDX    = (WAYBITS > 0) ? WAYBITS : 1;
    localparam int SLO     = BLOCKSIZEBITS;
    localparam int SHI     = SETBITS + BLOCKSIZEBITS - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WB, S_WB_GAP, S_FILL, S_FILL_GAP, S_RETURN
`ifdef CACHE_FLUSH_EN
        , S_FLUSH_SCAN
`endif
    } state_t;

    state_t r_state, w_next;

    logic [31:0]                    r_data [WAYS][SETS][WORDS];
    logic [TAGBITS-1:0]             r_tag  [WAYS][SETS];
    logic [WAYS-1:0][SETS-1:0]      r_valid;
    logic [WAYS-1:0][SETS-1:0]      r_dirty;
    logic [SETS-1:0][WIDX-1:0]      r_ptr;

    logic [31:0]                r_addr;
    logic [31:0]                r_wdata;
    logic                       r_rd;
    logic                       r_wr;
    logic [WIDX-1:0]            r_way;
    logic [BLOCKSIZEBITS-1:0]   r_off;

    logic [SETBITS-1:0]         w_set_in;
    logic [TAGBITS-1:0]         w_tag_in;
    logic [SETBITS-1:0]         w_set;
    logic                       w_req;
    logic                       w_hit;
    logic [WIDX-1:0]            w_hit_way;
    logic                       w_inv_found;
    logic [WIDX-1:0]            w_inv_way;
    logic [WIDX-1:0]            w_victim;
    logic                       w_vic_dirty;
    logic                       w_flushing;

    assign w_set_in = ProzessorAdresse[SHI:SLO];
    assign w_tag_in = ProzessorAdresse[31 -: TAGBITS];
    assign w_set    = r_addr[SHI:SLO];
    assign w_req    = ProzessorLesen | ProzessorSchreiben;

`ifdef CACHE_FLUSH_EN
    localparam int SCANBITS = SETBITS + WAYBITS;
    logic [SCANBITS-1:0] r_scan;
    logic                r_flushing;
    logic [SETBITS-1:0]  w_scan_set;
    logic [WIDX-1:0]     w_scan_way;
    logic                w_scan_dirty;

    assign w_scan_set   = r_scan[SCANBITS-1 -: SETBITS];
    assign w_scan_way   = (WAYBITS > 0) ? r_scan[WIDX-1:0] : '0;
    assign w_scan_dirty = r_valid[w_scan_way][w_scan_set] & r_dirty[w_scan_way][w_scan_set];
    assign w_flushing   = r_flushing;
`else
    assign w_flushing   = 1'b0;
`endif

    // Tag lookup and victim choice on the live request address
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[WIDX'(w)][w_set_in] && (r_tag[WIDX'(w)][w_set_in] == w_tag_in)) begin
                w_hit     = 1'b1;
                w_hit_way = WIDX'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[WIDX'(w)][w_set_in]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WIDX'(w);
            end
        end
        w_victim    = w_inv_found ? w_inv_way : r_ptr[w_set_in];
        w_vic_dirty = r_valid[w_victim][w_set_in] & r_dirty[w_victim][w_set_in];
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next                    = r_state;
        ProzessorLesDaten         = '0;
        ProzessorDatenGeschrieben = 1'b0;
        ProzessorDatenGelesen     = 1'b0;
        RAMSchreiben              = 1'b0;
        RAMLesen                  = 1'b0;
        RAMAdresse                = '0;
        RAMSchreibDaten           = '0;
`ifdef CACHE_FLUSH_EN
        FlushFertig               = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef CACHE_FLUSH_EN
                if (Flush) w_next = S_FLUSH_SCAN;
                else
`endif
                if (w_req) begin
                    if (w_hit)            w_next = S_RETURN;
                    else if (w_vic_dirty) w_next = S_WB;
                    else                  w_next = S_FILL;
                end
            end
            S_WB: begin
                RAMSchreiben    = 1'b1;
                RAMAdresse      = {r_tag[r_way][w_set], w_set, r_off};
                RAMSchreibDaten = r_data[r_way][w_set][r_off];
                if (RAMDatenGeschrieben) begin
                    if (r_off != '1) w_next = S_WB_GAP;
`ifdef CACHE_FLUSH_EN
                    else if (w_flushing) w_next = S_FLUSH_SCAN;
`endif
                    else w_next = S_FILL;
                end
            end
            S_WB_GAP: w_next = S_WB;
            S_FILL: begin
                RAMLesen   = 1'b1;
                RAMAdresse = {r_addr[31 -: TAGBITS], w_set, r_off};
                if (RAMDatenGelesen) w_next = (r_off == '1) ? S_RETURN : S_FILL_GAP;
            end
            S_FILL_GAP: w_next = S_FILL;
            S_RETURN: begin
                ProzessorDatenGelesen     = r_rd;
                ProzessorDatenGeschrieben = r_wr;
                if (r_rd) ProzessorLesDaten = r_data[r_way][w_set][r_addr[SLO-1:0]];
                w_next = S_IDLE;
            end
`ifdef CACHE_FLUSH_EN
            S_FLUSH_SCAN: begin
                if (w_scan_dirty) w_next = S_WB;
                else if (r_scan == '1) begin
                    FlushFertig = 1'b1;
                    w_next      = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Control state: request latch, line status bits, replacement pointers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_way   <= '0;
            r_off   <= '0;
            r_valid <= '0;
            r_dirty <= '0;
            r_ptr   <= '0;
`ifdef CACHE_FLUSH_EN
            r_scan     <= '0;
            r_flushing <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef CACHE_FLUSH_EN
                    if (Flush) begin
                        r_flushing <= 1'b1;
                        r_scan     <= '0;
                        r_off      <= '0;
                    end else
`endif
                    if (w_req) begin
                        r_addr  <= ProzessorAdresse;
                        r_wdata <= ProzessorSchreibDaten;
                        r_rd    <= ProzessorLesen;
                        r_wr    <= ProzessorSchreiben;
                        r_off   <= '0;
                        if (w_hit) begin
                            r_way <= w_hit_way;
                        end else begin
                            r_way <= w_victim;
                            // The victim stops being a valid line until its refill completes
                            r_valid[w_victim][w_set_in] <= 1'b0;
                            if (!w_inv_found)
                                r_ptr[w_set_in] <= (WAYBITS == 0) ? '0 : r_ptr[w_set_in] + 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (RAMDatenGeschrieben) begin
                        r_off <= r_off + 1'b1;
                        if ((r_off == '1) && w_flushing) r_dirty[r_way][w_set] <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (RAMDatenGelesen) begin
                        r_off <= r_off + 1'b1;
                        if (r_off == '1) begin
                            r_valid[r_way][w_set] <= 1'b1;
                            r_dirty[r_way][w_set] <= 1'b0;
                        end
                    end
                end
                S_RETURN: begin
                    if (r_wr) r_dirty[r_way][w_set] <= 1'b1;
                end
`ifdef CACHE_FLUSH_EN
                S_FLUSH_SCAN: begin
                    if (w_scan_dirty) begin
                        r_addr[SHI:SLO] <= w_scan_set;
                        r_way           <= w_scan_way;
                        r_off           <= '0;
                    end else if (r_scan == '1) begin
                        r_flushing <= 1'b0;
                    end else begin
                        r_scan <= r_scan + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Line storage; only written from FILL and RETURN, so reset needs no guard here
    always_ff @(posedge Clock) begin
        if ((r_state == S_FILL) && RAMDatenGelesen) begin
            r_data[r_way][w_set][r_off] <= RAMLesDaten;
            if (r_off == '1) r_tag[r_way][w_set] <= r_addr[31 -: TAGBITS];
        end
        if ((r_state == S_RETURN) && r_wr)
            r_data[r_way][w_set][r_addr[SLO-1:0]] <= r_wdata;
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed and randomized accesses checked against a line-level cache model.
// A second instance (WAYBITS=0, same set count) covers the direct-mapped build.
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps = 1'b0, pl = 1'b0;
    logic [31:0] pa = '0, pwd = '0;
    logic [31:0] prd;
    logic        pwack, prack;
    logic        rs, rl;
    logic [31:0] ra, rwd;
    logic [31:0] rrd = '0;
    logic        rwack = 1'b0, rrack = 1'b0;

    logic        d_pl = 1'b0;
    logic [31:0] d_pa = '0;
    logic [31:0] d_prd;
    logic        d_pwack, d_prack, d_rs, d_rl;
    logic [31:0] d_ra, d_rwd;
    logic [31:0] d_rrd = '0;
    logic        d_rwack = 1'b0, d_rrack = 1'b0;

`ifdef CACHE_FLUSH_EN
    logic flush = 1'b0, flush_done, d_flush_done;
`endif

    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    set_assoc_cache dut (
        .Clock(clk), .Reset(rst_n),
        .ProzessorSchreiben(ps), .ProzessorLesen(pl),
        .ProzessorAdresse(pa), .ProzessorSchreibDaten(pwd),
        .ProzessorLesDaten(prd), .ProzessorDatenGeschrieben(pwack), .ProzessorDatenGelesen(prack),
        .RAMSchreiben(rs), .RAMLesen(rl), .RAMAdresse(ra), .RAMSchreibDaten(rwd),
        .RAMLesDaten(rrd), .RAMDatenGeschrieben(rwack), .RAMDatenGelesen(rrack)
`ifdef CACHE_FLUSH_EN
        , .Flush(flush), .FlushFertig(flush_done)
`endif
    );

    set_assoc_cache #(.CACHESIZEBITS(12), .BLOCKSIZEBITS(2), .WAYBITS(0)) dut_dm (
        .Clock(clk), .Reset(rst_n),
        .ProzessorSchreiben(1'b0), .ProzessorLesen(d_pl),
        .ProzessorAdresse(d_pa), .ProzessorSchreibDaten(32'h0),
        .ProzessorLesDaten(d_prd), .ProzessorDatenGeschrieben(d_pwack), .ProzessorDatenGelesen(d_prack),
        .RAMSchreiben(d_rs), .RAMLesen(d_rl), .RAMAdresse(d_ra), .RAMSchreibDaten(d_rwd),
        .RAMLesDaten(d_rrd), .RAMDatenGeschrieben(d_rwack), .RAMDatenGelesen(d_rrack)
`ifdef CACHE_FLUSH_EN
        , .Flush(1'b0), .FlushFertig(d_flush_done)
`endif
    );

    typedef struct {bit wr; logic [31:0] a; logic [31:0] d;} ram_ev_t;
    ram_ev_t     ramlog[$];
    logic [31:0] ram [logic [31:0]];
    int          gap_viol = 0;
    logic        prev_rack = 1'b0, prev_wack = 1'b0;
    int          d_reads = 0;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : (32'h100 + {30'd0, a[1:0]});
    endfunction

    // RAM with one-cycle acknowledge; logs every transfer it accepts
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrack     <= 1'b0;
            rwack     <= 1'b0;
            prev_rack <= 1'b0;
            prev_wack <= 1'b0;
        end else begin
            if ((prev_rack && rl) || (prev_wack && rs)) gap_viol++;
            prev_rack <= rrack;
            prev_wack <= rwack;
            rrack <= 1'b0;
            rwack <= 1'b0;
            if (rl && !rrack) begin
                rrack <= 1'b1;
                rrd   <= ram_rd(ra);
                ramlog.push_back('{wr: 1'b0, a: ra, d: ram_rd(ra)});
            end
            if (rs && !rwack) begin
                rwack <= 1'b1;
                ram[ra] = rwd;
                ramlog.push_back('{wr: 1'b1, a: ra, d: rwd});
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rrack <= 1'b0;
            d_rwack <= 1'b0;
        end else begin
            d_rrack <= 1'b0;
            d_rwack <= 1'b0;
            if (d_rl && !d_rrack) begin
                d_rrack <= 1'b1;
                d_rrd   <= 32'h100 + {30'd0, d_ra[1:0]};
                d_reads++;
            end
            if (d_rs && !d_rwack) d_rwack <= 1'b1;
        end
    end

    // Reference model: per-set line table plus the processor-visible memory image
    bit          m_valid [1024][2];
    bit          m_dirty [1024][2];
    logic [19:0] m_tag   [1024][2];
    int          m_ptr   [1024];
    logic [31:0] m_mem   [logic [31:0]];

    function automatic logic [31:0] mval(input logic [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : (32'h100 + {30'd0, a[1:0]});
    endfunction

    function automatic logic [31:0] line_addr(input logic [19:0] tag, input int set, input int i);
        logic [9:0] s;
        logic [1:0] o;
        s = 10'(set);
        o = 2'(i);
        return {tag, s, o};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 1024; s++) begin
            for (int w = 0; w < 2; w++) begin
                if (m_valid[s][w] && m_dirty[s][w])
                    for (int i = 0; i < 4; i++) m_mem[line_addr(m_tag[s][w], s, i)] = ram_rd(line_addr(m_tag[s][w], s, i));
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            m_ptr[s] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic compare_log(input string nm, input int base, input ram_ev_t exp[$]);
        bit bad = 1'b0;
        n_cmp++;
        if (ramlog.size() - base != exp.size()) begin
            n_fail++;
            $display("FAIL %s ram_count: got %0d want %0d", nm, ramlog.size() - base, exp.size());
            return;
        end
        for (int k = 0; k < exp.size(); k++) begin
            if (!bad && (ramlog[base+k].wr !== exp[k].wr || ramlog[base+k].a !== exp[k].a || ramlog[base+k].d !== exp[k].d)) begin
                bad = 1'b1;
                $display("FAIL %s ram_seq[%0d]: got wr=%0b a=%h d=%h want wr=%0b a=%h d=%h", nm, k,
                         ramlog[base+k].wr, ramlog[base+k].a, ramlog[base+k].d, exp[k].wr, exp[k].a, exp[k].d);
            end
        end
        if (bad) n_fail++;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd, input string nm);
        ram_ev_t     exp[$];
        int          set = int'(a[11:2]);
        logic [19:0] tag = a[31:12];
        int          hw = -1, v = -1, cyc = 0, exp_cyc, base;
        bit          wb = 1'b0;
        logic [31:0] exp_rd;
        for (int w = 0; w < 2; w++) if (m_valid[set][w] && m_tag[set][w] == tag) hw = w;
        if (hw < 0) begin
            for (int w = 1; w >= 0; w--) if (!m_valid[set][w]) v = w;
            if (v < 0) begin
                v = m_ptr[set];
                m_ptr[set] = (m_ptr[set] + 1) % 2;
            end
            if (m_valid[set][v] && m_dirty[set][v]) begin
                wb = 1'b1;
                for (int i = 0; i < 4; i++) exp.push_back('{wr: 1'b1, a: line_addr(m_tag[set][v], set, i), d: mval(line_addr(m_tag[set][v], set, i))});
            end
            for (int i = 0; i < 4; i++) exp.push_back('{wr: 1'b0, a: line_addr(tag, set, i), d: mval(line_addr(tag, set, i))});
            m_valid[set][v] = 1'b1;
            m_dirty[set][v] = 1'b0;
            m_tag[set][v]   = tag;
            hw = v;
        end
        exp_cyc = (exp.size() == 0) ? 1 : (wb ? 23 : 12);
        exp_rd  = rd ? mval(a) : 32'h0;
        if (wr) begin
            m_mem[a] = wd;
            m_dirty[set][hw] = 1'b1;
        end

        base = ramlog.size();
        pl = rd; ps = wr; pa = a; pwd = wd;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!(prack || pwack) && cyc < 200);
        n_cmp++;
        if (cyc !== exp_cyc) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles want %0d", nm, cyc, exp_cyc);
        end
        n_cmp++;
        if (prack !== rd || pwack !== wr) begin
            n_fail++;
            $display("FAIL %s acks: got rd=%b wr=%b want rd=%b wr=%b", nm, prack, pwack, rd, wr);
        end
        n_cmp++;
        if (prd !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rdata: got %h want %h", nm, prd, exp_rd);
        end
        pl = 1'b0; ps = 1'b0;
        compare_log(nm, base, exp);
        @(negedge clk);
        n_cmp++;
        if (prack !== 1'b0 || pwack !== 1'b0) begin
            n_fail++;
            $display("FAIL %s single_ack: got rd=%b wr=%b want 0 0", nm, prack, pwack);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({prack, pwack, rs, rl} !== 4'b0 || prd !== 32'h0 || ra !== 32'h0 || rwd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b%b strobes=%b%b rdata=%h addr=%h wdata=%h want all 0",
                     prack, pwack, rs, rl, prd, ra, rwd);
        end
        n_cmp++;
        if ({d_prack, d_pwack, d_rs, d_rl} !== 4'b0 || d_ra !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_dm: got %b addr=%h want 0", {d_prack, d_pwack, d_rs, d_rl}, d_ra);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_cold_read();
        access(1'b1, 1'b0, 32'h40, 32'h0, "cold_read_40");
        access(1'b1, 1'b0, 32'h42, 32'h0, "hit_read_42");
    endtask

    task automatic test_eviction();
        access(1'b0, 1'b1, 32'h41, 32'hDEADBEEF, "write_hit_41");
        access(1'b1, 1'b0, 32'h1040, 32'h0, "fill_way1_1040");
        access(1'b1, 1'b0, 32'h2040, 32'h0, "evict_dirty_2040");
        access(1'b1, 1'b0, 32'h3040, 32'h0, "evict_clean_3040");
    endtask

    task automatic test_rw_together();
        access(1'b1, 1'b0, 32'h40, 32'h0, "refetch_40");
        access(1'b1, 1'b1, 32'h40, 32'h55, "rw_same_cycle_40");
        access(1'b1, 1'b0, 32'h40, 32'h0, "read_back_40");
    endtask

    task automatic test_random();
        logic [19:0] tg;
        logic [9:0]  st;
        logic [1:0]  off;
        int          op;
        for (int n = 0; n < 60; n++) begin
            tg  = 20'($urandom_range(0, 3));
            st  = ($urandom_range(0, 1) != 0) ? 10'h010 : 10'h011;
            off = 2'($urandom_range(0, 3));
            op  = $urandom_range(0, 2);
            access(op != 1, op != 0, {tg, st, off}, $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc = 0, base;
        do_reset();
        base = ramlog.size();
        pl = 1'b1; pa = 32'h40;
        while (!((ramlog.size() - base == 2) && rl && !rrack) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc >= 100) begin
            n_fail++;
            $display("FAIL reset_mid_fill_wait: got timeout want third fill strobe");
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rl !== 1'b0 || ra !== 32'h0 || prack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_fill_drop: got RAMLesen=%b addr=%h ack=%b want 0 0 0", rl, ra, prack);
        end
        pl = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        access(1'b1, 1'b0, 32'h40, 32'h0, "refill_after_reset");
    endtask

    task automatic test_direct_mapped();
        int base = d_reads, cyc;
        logic [31:0] a;
        for (int n = 0; n < 6; n++) begin
            a = (n % 2 == 0) ? 32'h40 : 32'h1040;
            d_pl = 1'b1; d_pa = a;
            cyc = 0;
            do begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end while (!d_prack && cyc < 200);
            n_cmp++;
            if (d_prack !== 1'b1 || d_prd !== 32'h100) begin
                n_fail++;
                $display("FAIL dm_read[%0d]: got ack=%b data=%h want 1 00000100", n, d_prack, d_prd);
            end
            d_pl = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (d_reads - base !== 24) begin
            n_fail++;
            $display("FAIL dm_ram_reads: got %0d want 24", d_reads - base);
        end
    endtask

`ifdef CACHE_FLUSH_EN
    task automatic test_flush();
        ram_ev_t exp[$];
        int base, cyc = 0, pulses = 0;
        do_reset();
        access(1'b0, 1'b1, 32'h40, 32'hA5A50040, "flush_prep_40");
        access(1'b0, 1'b1, 32'h1040, 32'hA5A51040, "flush_prep_1040");
        for (int s = 0; s < 1024; s++)
            for (int w = 0; w < 2; w++)
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    for (int i = 0; i < 4; i++) exp.push_back('{wr: 1'b1, a: line_addr(m_tag[s][w], s, i), d: mval(line_addr(m_tag[s][w], s, i))});
                    m_dirty[s][w] = 1'b0;
                end
        base = ramlog.size();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        while (!flush_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (flush_done) pulses++;
        @(negedge clk);
        if (flush_done) pulses++;
        n_cmp++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL flush_done_pulse: got %0d cycles high want 1", pulses);
        end
        compare_log("flush_writes", base, exp);
        access(1'b1, 1'b0, 32'h40, 32'h0, "flush_then_hit_40");
    endtask
`endif

    initial begin
        test_reset();
        test_cold_read();
        test_eviction();
        test_rw_together();
        test_random();
        test_reset_mid_fill();
        test_direct_mapped();
`ifdef CACHE_FLUSH_EN
        test_flush();
`endif
        n_cmp++;
        if (gap_viol !== 0) begin
            n_fail++;
            $display("FAIL ram_gap: got %0d back-to-back strobes want 0", gap_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
